// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory-wait freezes,
// load-use/RAW stalls, taken-branch flushes and a saturating lost-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int MEM_LATENCY = 4,
  parameter bit FWD_EN      = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  src1,
  input  logic [4:0]  src2,
  input  logic        two_src,
  input  logic [4:0]  EXE_Dest,
  input  logic        EXE_WB_EN,
  input  logic        EXE_MEM_R_EN,
  input  logic [4:0]  MEM_Dest,
  input  logic        MEM_WB_EN,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic        Br_taken,
  output logic        freeze_pc,
  output logic        freeze_if_id,
  output logic        flush_if_id,
  output logic        bubble_id_ex,
  output logic        freeze_id_ex,
  output logic        freeze_ex_mem,
  output logic        freeze_mem_wb,
  output logic        busy,
  output logic [31:0] stall_cycles
);

  typedef enum logic {IDLE, MEM_WAIT} state_e;

  localparam logic [3:0] CNT_INIT = (MEM_LATENCY > 1) ? 4'(MEM_LATENCY - 2) : 4'd0;
  localparam bit         MULTI    = (MEM_LATENCY > 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] stall_q;

  logic mem_req, hit_exe, hit_mem, lu, raw;

  assign mem_req = MEM_R_EN | MEM_W_EN;
  assign hit_exe = (EXE_Dest != 5'd0) &&
                   ((EXE_Dest == src1) || (two_src && (EXE_Dest == src2)));
  assign hit_mem = (MEM_Dest != 5'd0) &&
                   ((MEM_Dest == src1) || (two_src && (MEM_Dest == src2)));
  assign lu      = EXE_MEM_R_EN & EXE_WB_EN & hit_exe;
  assign raw     = FWD_EN ? lu : (lu | (EXE_WB_EN & hit_exe) | (MEM_WB_EN & hit_mem));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    freeze_pc     = 1'b0;
    freeze_if_id  = 1'b0;
    flush_if_id   = 1'b0;
    bubble_id_ex  = 1'b0;
    freeze_id_ex  = 1'b0;
    freeze_ex_mem = 1'b0;
    freeze_mem_wb = 1'b0;
    busy          = 1'b0;
    if (!rst) begin
      // The release cycle of MEM_WAIT ignores mem_req and falls through to the
      // branch/raw rules so a held branch is acted on there.
      if (state_q == IDLE && MULTI && mem_req) begin
        {freeze_pc, freeze_if_id, freeze_id_ex, freeze_ex_mem, freeze_mem_wb} = '1;
        state_d = MEM_WAIT;
        cnt_d   = CNT_INIT;
      end else if (state_q == MEM_WAIT && cnt_q != 4'd0) begin
        {freeze_pc, freeze_if_id, freeze_id_ex, freeze_ex_mem, freeze_mem_wb} = '1;
        cnt_d = cnt_q - 4'd1;
      end else begin
        state_d = IDLE;
        if (Br_taken) begin
          flush_if_id  = 1'b1;
          bubble_id_ex = 1'b1;
        end else if (raw) begin
          freeze_pc    = 1'b1;
          freeze_if_id = 1'b1;
          bubble_id_ex = 1'b1;
        end
      end
      busy = (state_q == MEM_WAIT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      stall_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if ((freeze_pc | flush_if_id) && (stall_q != 32'hFFFF_FFFF))
        stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench: three configurations share one stimulus stream;
// expectations are queued per step and checked on the falling edge.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] src1, src2, EXE_Dest, MEM_Dest;
  logic two_src, EXE_WB_EN, EXE_MEM_R_EN, MEM_WB_EN, MEM_R_EN, MEM_W_EN, Br_taken;

  always #5 clk = ~clk;

  // ctl = {freeze_pc, freeze_if_id, flush_if_id, bubble_id_ex,
  //        freeze_id_ex, freeze_ex_mem, freeze_mem_wb, busy}
  localparam logic [7:0] Z    = 8'b0000_0000;
  localparam logic [7:0] FALL = 8'b1100_1110;
  localparam logic [7:0] BUSY = 8'b0000_0001;
  localparam logic [7:0] STL  = 8'b1101_0000;
  localparam logic [7:0] BR   = 8'b0011_0000;

  logic [7:0]  ctl [3];
  logic [31:0] cnt [3];
  logic [7:0]  c0, c1, c2;
  assign ctl[0] = c0;
  assign ctl[1] = c1;
  assign ctl[2] = c2;

  pipeline_hazard_ctrl #(.MEM_LATENCY(4), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
    .EXE_Dest(EXE_Dest), .EXE_WB_EN(EXE_WB_EN), .EXE_MEM_R_EN(EXE_MEM_R_EN),
    .MEM_Dest(MEM_Dest), .MEM_WB_EN(MEM_WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .Br_taken(Br_taken), .freeze_pc(c0[7]), .freeze_if_id(c0[6]), .flush_if_id(c0[5]),
    .bubble_id_ex(c0[4]), .freeze_id_ex(c0[3]), .freeze_ex_mem(c0[2]),
    .freeze_mem_wb(c0[1]), .busy(c0[0]), .stall_cycles(cnt[0]));

  pipeline_hazard_ctrl #(.MEM_LATENCY(4), .FWD_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
    .EXE_Dest(EXE_Dest), .EXE_WB_EN(EXE_WB_EN), .EXE_MEM_R_EN(EXE_MEM_R_EN),
    .MEM_Dest(MEM_Dest), .MEM_WB_EN(MEM_WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .Br_taken(Br_taken), .freeze_pc(c1[7]), .freeze_if_id(c1[6]), .flush_if_id(c1[5]),
    .bubble_id_ex(c1[4]), .freeze_id_ex(c1[3]), .freeze_ex_mem(c1[2]),
    .freeze_mem_wb(c1[1]), .busy(c1[0]), .stall_cycles(cnt[1]));

  pipeline_hazard_ctrl #(.MEM_LATENCY(1), .FWD_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
    .EXE_Dest(EXE_Dest), .EXE_WB_EN(EXE_WB_EN), .EXE_MEM_R_EN(EXE_MEM_R_EN),
    .MEM_Dest(MEM_Dest), .MEM_WB_EN(MEM_WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .Br_taken(Br_taken), .freeze_pc(c2[7]), .freeze_if_id(c2[6]), .flush_if_id(c2[5]),
    .bubble_id_ex(c2[4]), .freeze_id_ex(c2[3]), .freeze_ex_mem(c2[2]),
    .freeze_mem_wb(c2[1]), .busy(c2[0]), .stall_cycles(cnt[2]));

  typedef struct {
    string       tag;
    logic [7:0]  c;
    logic [31:0] n;
    bit          k0;
    logic [7:0]  c0;
    bit          k1;
    logic [7:0]  c1;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int checks = 0;
  int errors = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      assert (ctl[0] === e.c) else begin
        errors++;
        $error("FAIL %s ctl: got %b want %b", e.tag, ctl[0], e.c);
      end
      checks++;
      assert (cnt[0] === e.n) else begin
        errors++;
        $error("FAIL %s stall_cycles: got %h want %h", e.tag, cnt[0], e.n);
      end
      if (e.k0) begin
        checks++;
        assert (ctl[1] === e.c0) else begin
          errors++;
          $error("FAIL %s nofwd ctl: got %b want %b", e.tag, ctl[1], e.c0);
        end
      end
      if (e.k1) begin
        checks++;
        assert (ctl[2] === e.c1) else begin
          errors++;
          $error("FAIL %s lat1 ctl: got %b want %b", e.tag, ctl[2], e.c1);
        end
      end
    end
  end

  task automatic clr();
    src1 = 5'd0; src2 = 5'd0; two_src = 1'b0; EXE_Dest = 5'd0; EXE_WB_EN = 1'b0;
    EXE_MEM_R_EN = 1'b0; MEM_Dest = 5'd0; MEM_WB_EN = 1'b0; MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0; Br_taken = 1'b0;
  endtask

  task automatic step(input string t, input logic [7:0] c, input logic [31:0] n,
                      input bit k0, input logic [7:0] x0, input bit k1, input logic [7:0] x1);
    exp_t x;
    x.tag = t; x.c = c; x.n = n; x.k0 = k0; x.c0 = x0; x.k1 = k1; x.c1 = x1;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic loaduse(input logic [4:0] d);
    clr();
    EXE_MEM_R_EN = 1'b1; EXE_WB_EN = 1'b1; EXE_Dest = d; src1 = 5'd5;
  endtask

  initial begin
    rst = 1'b1;
    clr();
    MEM_R_EN = 1'b1;
    @(posedge clk); #1;
    step("rst_hold", Z, 0, 1, Z, 1, Z);
    rst = 1'b0;
    clr();
    step("idle", Z, 0, 1, Z, 1, Z);
    loaduse(5'd5);
    step("loaduse", STL, 0, 1, STL, 1, STL);
    loaduse(5'd0);
    step("loaduse_r0", Z, 1, 1, Z, 1, Z);
    clr(); MEM_R_EN = 1'b1;
    step("mem_start", FALL, 1, 1, FALL, 1, Z);
    Br_taken = 1'b1;
    step("mem_wait1", FALL | BUSY, 2, 1, FALL | BUSY, 0, Z);
    step("mem_wait2", FALL | BUSY, 3, 1, FALL | BUSY, 0, Z);
    step("mem_release_br", BR | BUSY, 4, 1, BR | BUSY, 0, Z);
    clr();
    step("after_br", Z, 5, 1, Z, 1, Z);
    MEM_W_EN = 1'b1;
    step("b2b_start", FALL, 5, 0, Z, 1, Z);
    step("b2b_wait1", FALL | BUSY, 6, 0, Z, 0, Z);
    step("b2b_wait2", FALL | BUSY, 7, 0, Z, 0, Z);
    step("b2b_release", BUSY, 8, 0, Z, 0, Z);
    step("b2b_second", FALL, 8, 0, Z, 0, Z);
    step("b2b_wait", FALL | BUSY, 9, 0, Z, 0, Z);
    rst = 1'b1;
    step("rst_midwait", Z, 10, 1, Z, 1, Z);
    rst = 1'b0;
    clr();
    step("post_rst", Z, 0, 1, Z, 1, Z);
    step("post_rst_idle", Z, 0, 1, Z, 1, Z);
    MEM_WB_EN = 1'b1; MEM_Dest = 5'd7; src2 = 5'd7; two_src = 1'b1;
    step("nofwd_mem_src2", Z, 0, 1, STL, 1, Z);
    two_src = 1'b0;
    step("nofwd_one_src", Z, 0, 1, Z, 1, Z);
    clr(); EXE_WB_EN = 1'b1; EXE_Dest = 5'd3; src1 = 5'd3;
    step("nofwd_exe_raw", Z, 0, 1, STL, 1, Z);
    EXE_MEM_R_EN = 1'b1; Br_taken = 1'b1;
    step("br_over_raw", BR, 0, 1, BR, 1, BR);
    loaduse(5'd5);
    force dut.stall_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_q;
    step("sat0", STL, 32'hFFFF_FFFE, 0, Z, 0, Z);
    step("sat1", STL, 32'hFFFF_FFFF, 0, Z, 0, Z);
    step("sat2", STL, 32'hFFFF_FFFF, 0, Z, 0, Z);
    clr();
    step("sat_hold", Z, 32'hFFFF_FFFF, 0, Z, 0, Z);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
